// File: rtl/avg_scheduler.sv
// Block-average scheduler: tracks raster position of a monitored AXI4-Stream video
// feed, steers each pixel to its block accumulator, then walks the block averages out.
module avg_scheduler #(
    parameter int FRAME_WIDTH  = 1920,
    parameter int FRAME_HEIGHT = 1080,
    parameter int NUM_BLOCKS_X = 4,
    parameter int NUM_BLOCKS_Y = 2,
    localparam int NB   = NUM_BLOCKS_X * NUM_BLOCKS_Y,
    localparam int IDXW = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            s_axis_video_tvalid,
    input  logic            s_axis_video_tready,
    input  logic            s_axis_video_tuser,
    input  logic            s_axis_video_tlast,
    output logic            acc_en,
    output logic            acc_first,
    output logic [IDXW-1:0] acc_idx,
    output logic            rd_valid,
    output logic [IDXW-1:0] rd_idx,
    input  logic            rd_ready,
    output logic            frame_done,
    output logic            err_line,
    output logic            err_sof,
    output logic [15:0]     frame_cnt
);

    localparam int BW  = FRAME_WIDTH / NUM_BLOCKS_X;
    localparam int BH  = FRAME_HEIGHT / NUM_BLOCKS_Y;
    localparam int XW  = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam int YW  = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int BXW = (BW > 1) ? $clog2(BW) : 1;
    localparam int BYW = (BH > 1) ? $clog2(BH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_READOUT} state_t;

    state_t r_state, w_state_nxt;

    logic [XW-1:0]   r_x, w_px, w_x_nxt;
    logic [YW-1:0]   r_y, w_py, w_y_nxt;
    logic [BXW-1:0]  r_ix, w_pix, w_ix_nxt;
    logic [BYW-1:0]  r_iy, w_piy, w_iy_nxt;
    logic [IDXW-1:0] r_bidx, w_pbidx, w_bidx_nxt;
    logic [IDXW-1:0] r_rowbase, w_prow, w_rowbase_nxt;

    logic            r_acc_en, r_acc_first, r_rd_valid, r_frame_done, r_err_line, r_err_sof;
    logic [IDXW-1:0] r_acc_idx, r_rd_idx, w_rd_idx_nxt;
    logic [15:0]     r_frame_cnt;

    logic w_beat, w_sof, w_take, w_x_end, w_y_end, w_line_wrap, w_eof;
    logic w_err_line, w_err_sof, w_rd_xfer, w_rd_last, w_frame_done;

    // A start-of-frame beat is always pixel (0,0), whatever the counters say.
    always_comb begin
        w_beat      = s_axis_video_tvalid & s_axis_video_tready;
        w_sof       = w_beat & s_axis_video_tuser;
        w_px        = w_sof ? '0 : r_x;
        w_py        = w_sof ? '0 : r_y;
        w_pix       = w_sof ? '0 : r_ix;
        w_piy       = w_sof ? '0 : r_iy;
        w_pbidx     = w_sof ? '0 : r_bidx;
        w_prow      = w_sof ? '0 : r_rowbase;
        w_take      = w_beat & (s_axis_video_tuser | (r_state == S_ACCUM));
        w_x_end     = (w_px == XW'(FRAME_WIDTH - 1));
        w_y_end     = (w_py == YW'(FRAME_HEIGHT - 1));
        w_line_wrap = w_x_end | s_axis_video_tlast;
        w_eof       = w_take & w_x_end & w_y_end;
        w_err_line  = w_take & (s_axis_video_tlast ^ w_x_end);
        w_err_sof   = w_sof & (((r_state == S_ACCUM) & ((r_x != '0) | (r_y != '0)))
                               | (r_state == S_DRAIN) | (r_state == S_READOUT));
        w_rd_xfer   = r_rd_valid & rd_ready;
        w_rd_last   = (r_rd_idx == IDXW'(NB - 1));
    end

    always_comb begin
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_ix_nxt      = r_ix;
        w_iy_nxt      = r_iy;
        w_bidx_nxt    = r_bidx;
        w_rowbase_nxt = r_rowbase;
        if (w_take) begin
            if (w_eof) begin
                w_x_nxt       = '0;
                w_y_nxt       = '0;
                w_ix_nxt      = '0;
                w_iy_nxt      = '0;
                w_bidx_nxt    = '0;
                w_rowbase_nxt = '0;
            end else if (w_line_wrap) begin
                w_x_nxt  = '0;
                w_ix_nxt = '0;
                w_y_nxt  = w_y_end ? '0 : w_py + YW'(1);
                if (w_y_end) begin
                    w_iy_nxt      = '0;
                    w_rowbase_nxt = '0;
                end else if (w_piy == BYW'(BH - 1)) begin
                    w_iy_nxt      = '0;
                    w_rowbase_nxt = w_prow + IDXW'(NUM_BLOCKS_X);
                end else begin
                    w_iy_nxt      = w_piy + BYW'(1);
                    w_rowbase_nxt = w_prow;
                end
                w_bidx_nxt = w_rowbase_nxt;
            end else begin
                w_x_nxt       = w_px + XW'(1);
                w_y_nxt       = w_py;
                w_iy_nxt      = w_piy;
                w_rowbase_nxt = w_prow;
                if (w_pix == BXW'(BW - 1)) begin
                    w_ix_nxt   = '0;
                    w_bidx_nxt = w_pbidx + IDXW'(1);
                end else begin
                    w_ix_nxt   = w_pix + BXW'(1);
                    w_bidx_nxt = w_pbidx;
                end
            end
        end
    end

    // Any accepted pixel (including a restart) decides the state; otherwise DRAIN and READOUT advance.
    always_comb begin
        w_state_nxt  = r_state;
        w_frame_done = 1'b0;
        if (w_take) begin
            w_state_nxt = w_eof ? S_DRAIN : S_ACCUM;
        end else begin
            case (r_state)
                S_DRAIN: begin
                    w_state_nxt  = S_READOUT;
                    w_frame_done = 1'b1;
                end
                S_READOUT: begin
                    if (w_rd_xfer && w_rd_last) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = r_state;
            endcase
        end
        w_rd_idx_nxt = '0;
        if (w_state_nxt == S_READOUT && r_state == S_READOUT)
            w_rd_idx_nxt = w_rd_xfer ? r_rd_idx + IDXW'(1) : r_rd_idx;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_x         <= '0;
            r_y         <= '0;
            r_ix        <= '0;
            r_iy        <= '0;
            r_bidx      <= '0;
            r_rowbase   <= '0;
            r_acc_en    <= 1'b0;
            r_acc_first <= 1'b0;
            r_acc_idx   <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_idx    <= '0;
            r_frame_done <= 1'b0;
            r_err_line  <= 1'b0;
            r_err_sof   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_ix        <= w_ix_nxt;
            r_iy        <= w_iy_nxt;
            r_bidx      <= w_bidx_nxt;
            r_rowbase   <= w_rowbase_nxt;
            r_acc_en    <= w_take;
            r_acc_first <= w_take & (w_pix == '0) & (w_piy == '0);
            if (w_take) r_acc_idx <= w_pbidx;
            r_rd_valid  <= (w_state_nxt == S_READOUT);
            r_rd_idx    <= w_rd_idx_nxt;
            r_frame_done <= w_frame_done;
            r_err_line  <= w_err_line;
            r_err_sof   <= w_err_sof;
            if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign acc_en     = r_acc_en;
    assign acc_first  = r_acc_first;
    assign acc_idx    = r_acc_idx;
    assign rd_valid   = r_rd_valid;
    assign rd_idx     = r_rd_idx;
    assign frame_done = r_frame_done;
    assign err_line   = r_err_line;
    assign err_sof    = r_err_sof;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_avg_scheduler.sv
// Directed bench for avg_scheduler on an 8x4 frame split into 2x2 blocks of 4x2 pixels.
module tb_avg_scheduler;

    localparam int FW  = 8;
    localparam int FH  = 4;
    localparam int NBX = 2;
    localparam int NBY = 2;
    localparam int BW  = FW / NBX;
    localparam int BH  = FH / NBY;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        tvalid = 1'b0;
    logic        tready = 1'b0;
    logic        tuser = 1'b0;
    logic        tlast = 1'b0;
    logic        rd_ready = 1'b0;
    logic        acc_en, acc_first, rd_valid, frame_done, err_line, err_sof;
    logic [1:0]  acc_idx, rd_idx;
    logic [15:0] frame_cnt;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_frames = '0;

    avg_scheduler #(
        .FRAME_WIDTH (FW),
        .FRAME_HEIGHT(FH),
        .NUM_BLOCKS_X(NBX),
        .NUM_BLOCKS_Y(NBY)
    ) dut (
        .aclk               (aclk),
        .areset             (areset),
        .s_axis_video_tvalid(tvalid),
        .s_axis_video_tready(tready),
        .s_axis_video_tuser (tuser),
        .s_axis_video_tlast (tlast),
        .acc_en             (acc_en),
        .acc_first          (acc_first),
        .acc_idx            (acc_idx),
        .rd_valid           (rd_valid),
        .rd_idx             (rd_idx),
        .rd_ready           (rd_ready),
        .frame_done         (frame_done),
        .err_line           (err_line),
        .err_sof            (err_sof),
        .frame_cnt          (frame_cnt)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    function automatic logic [1:0] exp_idx(input int x, input int y);
        return 2'((y / BH) * NBX + x / BW);
    endfunction

    function automatic logic exp_first(input int x, input int y);
        return (x % BW == 0) && (y % BH == 0);
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic r, input logic u, input logic l);
        tvalid = v;
        tready = r;
        tuser  = u;
        tlast  = l;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rd_ready = 1'b0;
        areset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({acc_en, acc_first, acc_idx, rd_valid, rd_idx, frame_done, err_line, err_sof, frame_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b first=%b idx=%0d rdv=%b rdi=%0d done=%b el=%b es=%b cnt=%0d, want all 0",
                     acc_en, acc_first, acc_idx, rd_valid, rd_idx, frame_done, err_line, err_sof, frame_cnt);
        end
        areset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            n_checks++;
            if (acc_en !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_no_tuser cycle %0d: acc_en=%b, want 0", i, acc_en);
            end
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_full_frame();
        int x, y;
        rd_ready = 1'b1;
        for (int b = 0; b < FW * FH; b++) begin
            x = b % FW;
            y = b / FW;
            drive(1'b1, 1'b1, b == 0, x == FW - 1);
            tick();
            n_checks++;
            if (acc_en !== 1'b1 || acc_idx !== exp_idx(x, y) || acc_first !== exp_first(x, y)) begin
                n_fail++;
                $display("FAIL full_acc beat %0d: got en=%b idx=%0d first=%b, want en=1 idx=%0d first=%b",
                         b, acc_en, acc_idx, acc_first, exp_idx(x, y), exp_first(x, y));
            end
            n_checks++;
            if ({err_line, err_sof, frame_done, rd_valid} !== 4'b0000) begin
                n_fail++;
                $display("FAIL full_flags beat %0d: got el=%b es=%b done=%b rdv=%b, want all 0",
                         b, err_line, err_sof, frame_done, rd_valid);
            end
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        exp_frames++;
        n_checks++;
        if (frame_done !== 1'b1 || frame_cnt !== exp_frames || acc_en !== 1'b0) begin
            n_fail++;
            $display("FAIL full_done: got done=%b cnt=%0d en=%b, want done=1 cnt=%0d en=0",
                     frame_done, frame_cnt, acc_en, exp_frames);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_valid !== 1'b1 || rd_idx !== 2'(i) || (i > 0 && frame_done !== 1'b0)) begin
                n_fail++;
                $display("FAIL full_readout step %0d: got rdv=%b rdi=%0d done=%b, want rdv=1 rdi=%0d",
                         i, rd_valid, rd_idx, frame_done, i);
            end
            tick();
        end
        n_checks++;
        if (rd_valid !== 1'b0 || frame_cnt !== exp_frames) begin
            n_fail++;
            $display("FAIL full_readout_end: got rdv=%b cnt=%0d, want rdv=0 cnt=%0d", rd_valid, frame_cnt, exp_frames);
        end
    endtask

    task automatic test_gaps_backpressure();
        int   b, x;
        logic v, r;
        b = 0;
        rd_ready = 1'b1;
        for (int cyc = 0; cyc < 500 && b < FW * FH; cyc++) begin
            v = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 3) != 0);
            x = b % FW;
            drive(v, r, b == 0, x == FW - 1);
            tick();
            n_checks++;
            if (v && r) begin
                if (acc_en !== 1'b1 || acc_idx !== exp_idx(x, b / FW) || acc_first !== exp_first(x, b / FW)) begin
                    n_fail++;
                    $display("FAIL gaps_acc beat %0d: got en=%b idx=%0d first=%b, want en=1 idx=%0d first=%b",
                             b, acc_en, acc_idx, acc_first, exp_idx(x, b / FW), exp_first(x, b / FW));
                end
                b++;
            end else if (acc_en !== 1'b0) begin
                n_fail++;
                $display("FAIL gaps_idle cycle %0d: acc_en=%b, want 0", cyc, acc_en);
            end
        end
        if (b < FW * FH) begin
            n_checks++;
            n_fail++;
            $display("FAIL gaps_timeout: got %0d beats, want %0d", b, FW * FH);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        exp_frames++;
        n_checks++;
        if (frame_done !== 1'b1 || rd_valid !== 1'b1 || rd_idx !== 2'd0 || frame_cnt !== exp_frames) begin
            n_fail++;
            $display("FAIL gaps_done: got done=%b rdv=%b rdi=%0d cnt=%0d, want 1 1 0 %0d",
                     frame_done, rd_valid, rd_idx, frame_cnt, exp_frames);
        end
        tick();
        n_checks++;
        if (rd_idx !== 2'd1) begin
            n_fail++;
            $display("FAIL gaps_rd1: rd_idx=%0d, want 1", rd_idx);
        end
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (rd_valid !== 1'b1 || rd_idx !== 2'd1) begin
                n_fail++;
                $display("FAIL gaps_hold cycle %0d: got rdv=%b rdi=%0d, want rdv=1 rdi=1", i, rd_valid, rd_idx);
            end
        end
        rd_ready = 1'b1;
        tick();
        n_checks++;
        if (rd_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL gaps_rd2: rd_idx=%0d, want 2", rd_idx);
        end
        tick();
        n_checks++;
        if (rd_idx !== 2'd3 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL gaps_rd3: got rdv=%b rdi=%0d, want rdv=1 rdi=3", rd_valid, rd_idx);
        end
        tick();
        n_checks++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps_rd_end: rd_valid=%b, want 0", rd_valid);
        end
    endtask

    // Line 1 is cut short by tlast at x=5; line 2 runs to x=7 without tlast.
    task automatic test_line_errors();
        int   nb, len, n_err;
        logic l, exp_el;
        nb = 0;
        n_err = 0;
        rd_ready = 1'b1;
        for (int y = 0; y < FH; y++) begin
            len = (y == 1) ? 6 : FW;
            for (int x = 0; x < len; x++) begin
                l = (y == 1 && x == 5) || (y != 2 && x == FW - 1);
                exp_el = (y == 1 && x == 5) || (y == 2 && x == FW - 1);
                drive(1'b1, 1'b1, nb == 0, l);
                tick();
                nb++;
                if (err_line === 1'b1) n_err++;
                n_checks++;
                if (acc_en !== 1'b1 || acc_idx !== exp_idx(x, y) || acc_first !== exp_first(x, y)
                    || err_line !== exp_el || frame_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL line_beat (%0d,%0d): got en=%b idx=%0d first=%b el=%b done=%b, want en=1 idx=%0d first=%b el=%b done=0",
                             x, y, acc_en, acc_idx, acc_first, err_line, frame_done,
                             exp_idx(x, y), exp_first(x, y), exp_el);
                end
            end
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        exp_frames++;
        n_checks++;
        if (frame_done !== 1'b1 || nb != 30 || n_err != 2 || frame_cnt !== exp_frames) begin
            n_fail++;
            $display("FAIL line_done: got done=%b beats=%0d errs=%0d cnt=%0d, want done=1 beats=30 errs=2 cnt=%0d",
                     frame_done, nb, n_err, frame_cnt, exp_frames);
        end
        repeat (4) tick();
        n_checks++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL line_rd_end: rd_valid=%b, want 0", rd_valid);
        end
    endtask

    task automatic test_sof_mid_frame();
        int x;
        rd_ready = 1'b1;
        for (int b = 0; b < 10; b++) begin
            x = b % FW;
            drive(1'b1, 1'b1, b == 0, x == FW - 1);
            tick();
            n_checks++;
            if (acc_idx !== exp_idx(x, b / FW) || err_sof !== 1'b0) begin
                n_fail++;
                $display("FAIL sof_pre beat %0d: got idx=%0d es=%b, want idx=%0d es=0", b, acc_idx, err_sof, exp_idx(x, b / FW));
            end
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (err_sof !== 1'b1 || acc_en !== 1'b1 || acc_idx !== 2'd0 || acc_first !== 1'b1) begin
            n_fail++;
            $display("FAIL sof_restart: got es=%b en=%b idx=%0d first=%b, want 1 1 0 1", err_sof, acc_en, acc_idx, acc_first);
        end
        for (int b = 1; b < FW * FH; b++) begin
            x = b % FW;
            drive(1'b1, 1'b1, 1'b0, x == FW - 1);
            tick();
            n_checks++;
            if (acc_en !== 1'b1 || acc_idx !== exp_idx(x, b / FW) || acc_first !== exp_first(x, b / FW)
                || err_sof !== 1'b0 || frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL sof_post beat %0d: got en=%b idx=%0d first=%b es=%b done=%b, want en=1 idx=%0d first=%b es=0 done=0",
                         b, acc_en, acc_idx, acc_first, err_sof, frame_done, exp_idx(x, b / FW), exp_first(x, b / FW));
            end
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        exp_frames++;
        n_checks++;
        if (frame_done !== 1'b1 || frame_cnt !== exp_frames) begin
            n_fail++;
            $display("FAIL sof_done: got done=%b cnt=%0d, want done=1 cnt=%0d", frame_done, frame_cnt, exp_frames);
        end
        repeat (4) tick();
    endtask

    task automatic test_readout_abort();
        int x;
        rd_ready = 1'b1;
        for (int b = 0; b < FW * FH; b++) begin
            x = b % FW;
            drive(1'b1, 1'b1, b == 0, x == FW - 1);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        exp_frames++;
        tick();
        tick();
        rd_ready = 1'b0;
        tick();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_idx !== 2'd2 || frame_cnt !== exp_frames) begin
            n_fail++;
            $display("FAIL abort_pre: got rdv=%b rdi=%0d cnt=%0d, want rdv=1 rdi=2 cnt=%0d", rd_valid, rd_idx, frame_cnt, exp_frames);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (err_sof !== 1'b1 || rd_valid !== 1'b0 || acc_en !== 1'b1 || acc_idx !== 2'd0
            || acc_first !== 1'b1 || frame_cnt !== exp_frames || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_sof: got es=%b rdv=%b en=%b idx=%0d first=%b cnt=%0d done=%b, want 1 0 1 0 1 %0d 0",
                     err_sof, rd_valid, acc_en, acc_idx, acc_first, frame_cnt, frame_done, exp_frames);
        end
        for (int b = 1; b < FW * FH; b++) begin
            x = b % FW;
            drive(1'b1, 1'b1, 1'b0, x == FW - 1);
            tick();
            if (b == 1) begin
                n_checks++;
                if (acc_en !== 1'b1 || acc_idx !== 2'd0 || acc_first !== 1'b0 || err_sof !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_accum: got en=%b idx=%0d first=%b es=%b, want 1 0 0 0", acc_en, acc_idx, acc_first, err_sof);
                end
            end
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        exp_frames++;
        tick();
        n_checks++;
        if (rd_valid !== 1'b1 || frame_cnt !== exp_frames) begin
            n_fail++;
            $display("FAIL abort_next_readout: got rdv=%b cnt=%0d, want rdv=1 cnt=%0d", rd_valid, frame_cnt, exp_frames);
        end
    endtask

    task automatic test_reset_readout();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        n_checks++;
        if (rd_idx !== 2'd1 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: got rdv=%b rdi=%0d, want rdv=1 rdi=1", rd_valid, rd_idx);
        end
        #2;
        areset = 1'b1;
        #1;
        n_checks++;
        if ({acc_en, acc_first, acc_idx, rd_valid, rd_idx, frame_done, err_line, err_sof, frame_cnt} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got en=%b first=%b idx=%0d rdv=%b rdi=%0d done=%b el=%b es=%b cnt=%0d, want all 0",
                     acc_en, acc_first, acc_idx, rd_valid, rd_idx, frame_done, err_line, err_sof, frame_cnt);
        end
        #1;
        areset = 1'b0;
        exp_frames = '0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            n_checks++;
            if (acc_en !== 1'b0 || rd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_no_tuser cycle %0d: got en=%b rdv=%b, want 0 0", i, acc_en, rd_valid);
            end
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (acc_en !== 1'b1 || acc_idx !== 2'd0 || acc_first !== 1'b1 || err_sof !== 1'b0 || frame_cnt !== exp_frames) begin
            n_fail++;
            $display("FAIL rst_restart: got en=%b idx=%0d first=%b es=%b cnt=%0d, want 1 0 1 0 0",
                     acc_en, acc_idx, acc_first, err_sof, frame_cnt);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gaps_backpressure();
        test_line_errors();
        test_sof_mid_frame();
        test_readout_abort();
        test_reset_readout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
